debounce_sync: RTL and testbench

- Input conditioning stage that sits directly upstream of the design's D flip-flop. It drives that flop's d input from a raw asynchronous level such as a pushbutton or external pin.
- Raw input passes through an N-flop synchronizer, then a counter-based debounce FSM. It produces a clean registered level plus one-cycle rise/fall strobes.
- Removes metastability and contact bounce before the signal enters the clk domain.

---
 rtl/debounce_sync.sv | 156 +++++++++++++++
 tb/tb_debounce_sync.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_sync.sv
// debounce_sync: SYNC_STAGES-deep synchronizer feeding a counter debounce FSM; clean level plus rise/fall strobes.
// Latency: q_db follows a held d_raw change SYNC_STAGES + DEBOUNCE_CYCLES edges after the first sampling edge.
// No backpressure; DEBOUNCE_GLITCH_CNT_EN adds a saturating glitch_cnt output.
module debounce_sync #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 8,
    parameter int   CNT_W           = 4,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_raw,
    output logic       q_db,
    output logic       rise,
    output logic       fall,
    output logic       busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_STABLE_LOW  = 2'd0,
        ST_WAIT_HIGH   = 2'd1,
        ST_STABLE_HIGH = 2'd2,
        ST_WAIT_LOW    = 2'd3
    } state_e;

    localparam state_e RESET_STATE = RESET_VAL ? ST_STABLE_HIGH : ST_STABLE_LOW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   d_s;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   q_db_q, q_db_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   abort;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_raw};
    end

    assign d_s = sync_q[SYNC_STAGES-1];

    // State register: reset wins over any in-progress qualification.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= {SYNC_STAGES{RESET_VAL}};
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            q_db_q  <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_db_q  <= q_db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next-state: any reversal during a WAIT state drops back with a cleared count.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        abort   = 1'b0;
        unique case (state_q)
            ST_STABLE_LOW: begin
                if (d_s) begin
                    state_d = ST_WAIT_HIGH;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_WAIT_HIGH: begin
                if (!d_s) begin
                    state_d = ST_STABLE_LOW;
                    abort   = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_STABLE_HIGH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STABLE_HIGH: begin
                if (!d_s) begin
                    state_d = ST_WAIT_LOW;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_WAIT_LOW: begin
                if (d_s) begin
                    state_d = ST_STABLE_HIGH;
                    abort   = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_STABLE_LOW;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    // Outputs: strobes are registered from the accepting transition so they align with q_db.
    always_comb begin
        q_db_d = q_db_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (state_q == ST_WAIT_HIGH && state_d == ST_STABLE_HIGH) begin
            q_db_d = 1'b1;
            rise_d = 1'b1;
        end
        if (state_q == ST_WAIT_LOW && state_d == ST_STABLE_LOW) begin
            q_db_d = 1'b0;
            fall_d = 1'b1;
        end
    end

    assign q_db = q_db_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = (state_q == ST_WAIT_HIGH) || (state_q == ST_WAIT_LOW);

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt_q, glitch_cnt_d;

    always_comb begin
        glitch_cnt_d = glitch_cnt_q;
        if (abort && glitch_cnt_q != 8'hFF) begin
            glitch_cnt_d = glitch_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_cnt_q <= 8'd0;
        end else begin
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign glitch_cnt = glitch_cnt_q;
`else
    logic unused_abort;
    assign unused_abort = abort;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: directed vectors with literal expectations plus a per-cycle windowed model compare.
module tb_debounce_sync;

    localparam int   SS   = 2;
    localparam int   DC   = 8;
    localparam logic RV   = 1'b0;
    localparam int   MAXE = 4096;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic d_raw = 1'b1;
    logic q_db, rise, fall, busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    debounce_sync #(
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (4),
        .RESET_VAL      (RV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .d_raw     (d_raw),
        .q_db      (q_db),
        .rise      (rise),
        .fall      (fall),
        .busy      (busy)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt(glitch_cnt)
`endif
    );

    // Model: d_s is d_raw delayed SS edges (reset value if any of those edges was a reset);
    // the level flips once the last DC synchronized samples since the last reset all disagree with it.
    bit rst_h [MAXE];
    bit raw_h [MAXE];
    bit ds_h  [MAXE];
    int edge_n   = 0;
    int last_chg = 0;
    bit m_q      = RV;
    bit m_rise   = 1'b0;
    bit m_fall   = 1'b0;
    bit m_busy   = 1'b0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    int m_glitch = 0;
`endif

    always @(posedge clk) begin : model_p
        bit ds;
        bit flip;
        edge_n = edge_n + 1;
        rst_h[edge_n] = rst;
        raw_h[edge_n] = d_raw;
        ds = (edge_n > SS) ? raw_h[edge_n-SS] : RV;
        for (int k = 1; k <= SS; k++) begin
            if (edge_n - k < 1) ds = RV;
            else if (rst_h[edge_n-k]) ds = RV;
        end
        ds_h[edge_n] = ds;
        if (rst) begin
            m_q      = RV;
            m_rise   = 1'b0;
            m_fall   = 1'b0;
            m_busy   = 1'b0;
            last_chg = edge_n;
`ifdef DEBOUNCE_GLITCH_CNT_EN
            m_glitch = 0;
`endif
        end else begin
            flip = (edge_n - last_chg >= DC);
            if (flip) begin
                for (int k = 0; k < DC; k++) begin
                    if (ds_h[edge_n-k] == m_q) flip = 1'b0;
                end
            end
`ifdef DEBOUNCE_GLITCH_CNT_EN
            if (m_busy && ds == m_q && m_glitch < 255) m_glitch = m_glitch + 1;
`endif
            m_rise = flip && !m_q;
            m_fall = flip && m_q;
            if (flip) begin
                m_q      = ~m_q;
                last_chg = edge_n;
            end
            m_busy = (ds != m_q);
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, act, exp);
        end
    endtask

    // Literal expectation: checks the DUT and pins the model to the same hand-computed value.
    task automatic lit(input string name, input logic [7:0] act, input logic [7:0] mdl,
                       input logic [7:0] exp);
        chk(name, act, exp);
        chk({name, "_model"}, mdl, exp);
    endtask

    always @(negedge clk) begin
        if (edge_n > 0) begin
            chk("cyc_q_db", {7'd0, q_db}, {7'd0, m_q});
            chk("cyc_rise", {7'd0, rise}, {7'd0, m_rise});
            chk("cyc_fall", {7'd0, fall}, {7'd0, m_fall});
            chk("cyc_busy", {7'd0, busy}, {7'd0, m_busy});
            chk("cyc_excl", {7'd0, rise & fall}, 8'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
            chk("cyc_glitch", glitch_cnt, 8'(m_glitch));
`endif
        end
    end

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int busy_n;
        rst   = 1'b1;
        d_raw = 1'b1;
        // Reset held two cycles with d_raw high
        tick(1);
        lit("rst1_q",    {7'd0, q_db}, {7'd0, m_q},    8'd0);
        lit("rst1_busy", {7'd0, busy}, {7'd0, m_busy}, 8'd0);
        tick(1);
        lit("rst2_q",    {7'd0, q_db}, {7'd0, m_q},    8'd0);
        lit("rst2_rise", {7'd0, rise}, {7'd0, m_rise}, 8'd0);
        rst = 1'b0;
        tick(3);
        lit("post_rst_busy_e3", {7'd0, busy}, {7'd0, m_busy}, 8'd1);
        tick(6);
        lit("post_rst_q_e9",  {7'd0, q_db}, {7'd0, m_q},    8'd0);
        tick(1);
        lit("post_rst_q_e10", {7'd0, q_db}, {7'd0, m_q},    8'd1);
        lit("post_rst_rise",  {7'd0, rise}, {7'd0, m_rise}, 8'd1);
        tick(1);
        lit("post_rst_rise_e11", {7'd0, rise}, {7'd0, m_rise}, 8'd0);

        // Release
        d_raw = 1'b0;
        tick(9);
        lit("rel_q_e9",  {7'd0, q_db}, {7'd0, m_q},    8'd1);
        tick(1);
        lit("rel_q_e10", {7'd0, q_db}, {7'd0, m_q},    8'd0);
        lit("rel_fall",  {7'd0, fall}, {7'd0, m_fall}, 8'd1);
        lit("rel_rise",  {7'd0, rise}, {7'd0, m_rise}, 8'd0);
        tick(1);
        lit("rel_fall_e11", {7'd0, fall}, {7'd0, m_fall}, 8'd0);
        tick(8);

        // Clean press held 20 cycles
        d_raw = 1'b1;
        tick(2);
        lit("press_busy_e2", {7'd0, busy}, {7'd0, m_busy}, 8'd0);
        tick(1);
        lit("press_busy_e3", {7'd0, busy}, {7'd0, m_busy}, 8'd1);
        tick(6);
        lit("press_q_e9",  {7'd0, q_db}, {7'd0, m_q},    8'd0);
        tick(1);
        lit("press_q_e10", {7'd0, q_db}, {7'd0, m_q},    8'd1);
        lit("press_rise",  {7'd0, rise}, {7'd0, m_rise}, 8'd1);
        tick(1);
        lit("press_rise_e11", {7'd0, rise}, {7'd0, m_rise}, 8'd0);
        lit("press_busy_e11", {7'd0, busy}, {7'd0, m_busy}, 8'd0);
        tick(9);
        d_raw = 1'b0;
        tick(12);

        // Bounce: 1,0,1,0 two cycles each, then settle high
        for (int i = 0; i < 4; i++) begin
            d_raw = (i % 2 == 0);
            tick(2);
        end
        d_raw = 1'b1;
        tick(9);
        lit("bounce_q_e9",  {7'd0, q_db}, {7'd0, m_q},    8'd0);
        tick(1);
        lit("bounce_q_e10", {7'd0, q_db}, {7'd0, m_q},    8'd1);
        lit("bounce_rise",  {7'd0, rise}, {7'd0, m_rise}, 8'd1);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        lit("bounce_glitch", glitch_cnt, 8'(m_glitch), 8'd2);
`endif
        tick(2);
        d_raw = 1'b0;
        tick(12);

        // Reset in the middle of a qualification
        d_raw = 1'b1;
        tick(5);
        lit("midrst_busy_e5", {7'd0, busy}, {7'd0, m_busy}, 8'd1);
        rst = 1'b1;
        tick(1);
        lit("midrst_q",    {7'd0, q_db}, {7'd0, m_q},    8'd0);
        lit("midrst_busy", {7'd0, busy}, {7'd0, m_busy}, 8'd0);
        lit("midrst_rise", {7'd0, rise}, {7'd0, m_rise}, 8'd0);
        rst = 1'b0;
        tick(9);
        lit("midrst_q_e9",  {7'd0, q_db}, {7'd0, m_q},    8'd0);
        tick(1);
        lit("midrst_q_e10", {7'd0, q_db}, {7'd0, m_q},    8'd1);
        lit("midrst_rise_e10", {7'd0, rise}, {7'd0, m_rise}, 8'd1);
        tick(2);
        d_raw = 1'b0;
        tick(12);

        // Single-cycle glitch
        d_raw = 1'b1;
        tick(1);
        d_raw = 1'b0;
        busy_n = (busy === 1'b1) ? 1 : 0;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            if (busy === 1'b1) busy_n = busy_n + 1;
        end
        lit("glitch_busy_cycles", 8'(busy_n), 8'(busy_n), 8'd1);
        lit("glitch_q", {7'd0, q_db}, {7'd0, m_q}, 8'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        lit("glitch_cnt_total", glitch_cnt, 8'(m_glitch), 8'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
